// File: rtl/sram_bus_pkg.sv
// Shared owner tags, transfer-size encodings and arbitration state for the SRAM bus arbiter.
// Owner tag is the single bit stored per outstanding request in the owner FIFO.
package sram_bus_pkg;

    localparam logic OWNER_INST = 1'b0;
    localparam logic OWNER_DATA = 1'b1;

    localparam logic [1:0] SIZE_BYTE = 2'd0;
    localparam logic [1:0] SIZE_HALF = 2'd1;
    localparam logic [1:0] SIZE_WORD = 2'd2;

    // ARB_OPEN: free to arbitrate; ARB_LOCK_*: a request sits on the bus unaccepted.
    typedef enum logic [1:0] {
        ARB_OPEN      = 2'd0,
        ARB_LOCK_INST = 2'd1,
        ARB_LOCK_DATA = 2'd2
    } arb_state_e;

    // Unlocked choice: contention resolved by prio, otherwise whoever is asking.
    function automatic logic pick_owner(input logic data_req, input logic both_req,
                                        input logic prio);
        if (both_req)
            return prio;
        return data_req ? OWNER_DATA : OWNER_INST;
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_owner_fifo.sv
// Owner FIFO: one tag bit per accepted-but-unanswered request, DEPTH entries (power of 2).
// Zero latency: head reflects the oldest entry combinationally; push ignored when full, pop when empty.
// Backpressure: full/count let the arbiter stop issuing; simultaneous push+pop keeps count.
module owner_fifo #(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     push_owner,
    input  logic                     pop,
    output logic                     head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [DEPTH-1:0] slots;
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == (PTR_W+1)'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = slots[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                slots[wr_ptr] <= push_owner;
                wr_ptr        <= wr_ptr + PTR_W'(1);
            end
            if (do_pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({do_push, do_pop})
                2'b10:   count <= count + (PTR_W+1)'(1);
                2'b01:   count <= count - (PTR_W+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares one SRAM-like bus between the IF and MEM ports; ARB_ROUND_ROBIN_EN makes contention alternate.
// Latency: zero-cycle combinational grant/mux; responses demuxed in issue order via the owner FIFO.
// Backpressure: bus_req drops when MAX_OUT requests are outstanding; an unaccepted request locks the grant.
module sram_bus_arbiter
    import sram_bus_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MAX_OUT = 2
) (
    input  logic              clk,
    input  logic              rst,

    input  logic              inst_req,
    input  logic              inst_wr,
    input  logic [1:0]        inst_size,
    input  logic [3:0]        inst_wstrb,
    input  logic [ADDR_W-1:0] inst_addr,
    input  logic [DATA_W-1:0] inst_wdata,
    output logic              inst_addr_ok,
    output logic              inst_data_ok,
    output logic [DATA_W-1:0] inst_rdata,

    input  logic              data_req,
    input  logic              data_wr,
    input  logic [1:0]        data_size,
    input  logic [3:0]        data_wstrb,
    input  logic [ADDR_W-1:0] data_addr,
    input  logic [DATA_W-1:0] data_wdata,
    output logic              data_addr_ok,
    output logic              data_data_ok,
    output logic [DATA_W-1:0] data_rdata,

    output logic              bus_req,
    output logic              bus_wr,
    output logic [1:0]        bus_size,
    output logic [3:0]        bus_wstrb,
    output logic [ADDR_W-1:0] bus_addr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic              bus_addr_ok,
    input  logic              bus_data_ok,
    input  logic [DATA_W-1:0] bus_rdata,

    output logic              err_resp
);

    localparam int CNT_W = $clog2(MAX_OUT) + 1;

    arb_state_e       state_q;
    arb_state_e       state_d;
    logic             grant;
    logic             prio;
    logic             both_req;
    logic             accept;
    logic             resp_vld;
    logic             fifo_head;
    logic             fifo_full;
    logic             fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    assign both_req = inst_req & data_req;

`ifdef ARB_ROUND_ROBIN_EN
    logic prio_q;

    // After a contended accept the loser gets first pick next time.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            prio_q <= OWNER_DATA;
        else if (accept && both_req)
            prio_q <= ~grant;
    end

    assign prio = prio_q;
`else
    assign prio = OWNER_DATA;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= ARB_OPEN;
        else
            state_q <= state_d;
    end

    // A locked owner keeps the bus; if it withdraws, fall back to normal arbitration.
    always_comb begin
        state_d = ARB_OPEN;
        grant   = pick_owner(data_req, both_req, prio);
        case (state_q)
            ARB_LOCK_INST: if (inst_req) grant = OWNER_INST;
            ARB_LOCK_DATA: if (data_req) grant = OWNER_DATA;
            default:       ;
        endcase
        if (bus_req && !bus_addr_ok)
            state_d = (grant == OWNER_DATA) ? ARB_LOCK_DATA : ARB_LOCK_INST;
    end

    // Full blocks issue even when a response frees a slot this same cycle.
    assign bus_req = (inst_req | data_req) & ~fifo_full & ~rst;
    assign accept  = bus_req & bus_addr_ok;

    assign bus_wr    = (grant == OWNER_DATA) ? data_wr    : inst_wr;
    assign bus_size  = (grant == OWNER_DATA) ? data_size  : inst_size;
    assign bus_wstrb = (grant == OWNER_DATA) ? data_wstrb : inst_wstrb;
    assign bus_addr  = (grant == OWNER_DATA) ? data_addr  : inst_addr;
    assign bus_wdata = (grant == OWNER_DATA) ? data_wdata : inst_wdata;

    assign inst_addr_ok = accept & (grant == OWNER_INST);
    assign data_addr_ok = accept & (grant == OWNER_DATA);

    owner_fifo #(
        .DEPTH (MAX_OUT)
    ) u_owner_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (accept),
        .push_owner (grant),
        .pop        (resp_vld),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Head is the pre-push entry, so a same-cycle accept never answers itself.
    assign resp_vld     = bus_data_ok & ~fifo_empty;
    assign inst_data_ok = resp_vld & (fifo_head == OWNER_INST);
    assign data_data_ok = resp_vld & (fifo_head == OWNER_DATA);
    assign inst_rdata   = bus_rdata;
    assign data_rdata   = bus_rdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            err_resp <= 1'b0;
        else if (bus_data_ok && fifo_count == '0)
            err_resp <= 1'b1;
    end

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Directed table-driven bench for sram_bus_arbiter plus hand-written reset and contention sequences.
module tb_sram_bus_arbiter;
    import sram_bus_pkg::*;

    localparam logic [31:0] IADDR = 32'h1c00_0000;
    localparam logic [31:0] DADDR = 32'h8000_0010;
`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_req, inst_wr, data_req, data_wr;
    logic [1:0]  inst_size, data_size, bus_size;
    logic [3:0]  inst_wstrb, data_wstrb, bus_wstrb;
    logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
    logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
    logic [31:0] inst_rdata, data_rdata;
    logic        bus_req, bus_wr, bus_addr_ok, bus_data_ok, err_resp;
    logic [31:0] bus_addr, bus_wdata, bus_rdata;

    int tests  = 0;
    int failed = 0;

    always #5 clk = ~clk;

    sram_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_OUT(2)) dut (
        .clk(clk), .rst(rst),
        .inst_req(inst_req), .inst_wr(inst_wr), .inst_size(inst_size), .inst_wstrb(inst_wstrb),
        .inst_addr(inst_addr), .inst_wdata(inst_wdata), .inst_addr_ok(inst_addr_ok),
        .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size), .data_wstrb(data_wstrb),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_addr_ok(data_addr_ok),
        .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .bus_req(bus_req), .bus_wr(bus_wr), .bus_size(bus_size), .bus_wstrb(bus_wstrb),
        .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_addr_ok(bus_addr_ok),
        .bus_data_ok(bus_data_ok), .bus_rdata(bus_rdata), .err_resp(err_resp)
    );

    typedef struct {
        logic        ireq, dreq, aok, dok;
        logic [31:0] rdata;
        logic        e_breq, e_iaok, e_daok, e_idok, e_ddok, e_grant, e_err;
    } vec_t;

    localparam int NV = 22;
    vec_t vecs[NV];

    function automatic vec_t mk(logic ireq, logic dreq, logic aok, logic dok, logic [31:0] rd,
                                logic breq, logic iaok, logic daok, logic idok, logic ddok,
                                logic g, logic err);
        vec_t v;
        v.ireq = ireq; v.dreq = dreq; v.aok = aok; v.dok = dok; v.rdata = rd;
        v.e_breq = breq; v.e_iaok = iaok; v.e_daok = daok;
        v.e_idok = idok; v.e_ddok = ddok; v.e_grant = g; v.e_err = err;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(input logic ireq, input logic dreq, input logic aok, input logic dok,
                         input logic [31:0] rd);
        inst_req = ireq; data_req = dreq; bus_addr_ok = aok; bus_data_ok = dok; bus_rdata = rd;
    endtask

    initial begin
        logic g, prev_g;
        inst_wr = 1'b0; inst_size = SIZE_WORD; inst_wstrb = 4'h0;
        inst_addr = IADDR; inst_wdata = 32'h0;
        data_wr = 1'b1; data_size = SIZE_WORD; data_wstrb = 4'hf;
        data_addr = DADDR; data_wdata = 32'h1234_5678;

        //               ireq dreq aok dok rdata         breq iaok daok idok ddok grant      err
        vecs[0]  = mk(1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0, OWNER_INST, 0);
        vecs[1]  = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, OWNER_INST, 0);
        vecs[2]  = mk(0, 0, 0, 1, 32'h0280_0413, 0, 0, 0, 1, 0, OWNER_INST, 0);
        vecs[3]  = mk(1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, OWNER_DATA, 0);
        vecs[4]  = mk(1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0, OWNER_INST, 0);
        vecs[5]  = mk(0, 0, 0, 1, 32'hA1A1_A1A1, 0, 0, 0, 0, 1, OWNER_INST, 0);
        vecs[6]  = mk(0, 0, 0, 1, 32'hB2B2_B2B2, 0, 0, 0, 1, 0, OWNER_INST, 0);
        vecs[7]  = mk(1, 0, 0, 0, 32'h0,         1, 0, 0, 0, 0, OWNER_INST, 0);
        vecs[8]  = mk(1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, OWNER_INST, 0);
        vecs[9]  = mk(1, 1, 0, 0, 32'h0,         1, 0, 0, 0, 0, OWNER_INST, 0);
        vecs[10] = mk(1, 1, 1, 0, 32'h0,         1, 1, 0, 0, 0, OWNER_INST, 0);
        vecs[11] = mk(0, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, OWNER_DATA, 0);
        vecs[12] = mk(1, 1, 1, 0, 32'h0,         0, 0, 0, 0, 0, OWNER_INST, 0);
        vecs[13] = mk(1, 1, 1, 1, 32'hC3C3_C3C3, 0, 0, 0, 1, 0, OWNER_INST, 0);
        vecs[14] = mk(1, 1, 1, 0, 32'h0,         1, 0, 1, 0, 0, OWNER_DATA, 0);
        vecs[15] = mk(1, 0, 1, 1, 32'hD4D4_D4D4, 0, 0, 0, 0, 1, OWNER_INST, 0);
        vecs[16] = mk(1, 0, 1, 1, 32'hE5E5_E5E5, 1, 1, 0, 0, 1, OWNER_INST, 0);
        vecs[17] = mk(0, 0, 0, 1, 32'hF6F6_F6F6, 0, 0, 0, 1, 0, OWNER_INST, 0);
        vecs[18] = mk(0, 0, 0, 1, 32'h7777_7777, 0, 0, 0, 0, 0, OWNER_INST, 0);
        vecs[19] = mk(0, 0, 0, 0, 32'h0,         0, 0, 0, 0, 0, OWNER_INST, 1);
        vecs[20] = mk(1, 0, 1, 0, 32'h0,         1, 1, 0, 0, 0, OWNER_INST, 1);
        vecs[21] = mk(0, 0, 0, 1, 32'h8888_8888, 0, 0, 0, 1, 0, OWNER_INST, 1);

        // Reset: outputs quiet even with every input asserted.
        rst = 1'b1;
        drive(1, 1, 1, 1, 32'h0);
        @(negedge clk);
        chk("rst_bus_req", bus_req, 0);
        chk("rst_inst_addr_ok", inst_addr_ok, 0);
        chk("rst_data_addr_ok", data_addr_ok, 0);
        chk("rst_inst_data_ok", inst_data_ok, 0);
        chk("rst_data_data_ok", data_data_ok, 0);
        chk("rst_err_resp", err_resp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 0, 32'h0);

        for (int i = 0; i < NV; i++) begin
            @(posedge clk); #1;
            drive(vecs[i].ireq, vecs[i].dreq, vecs[i].aok, vecs[i].dok, vecs[i].rdata);
            @(negedge clk);
            chk($sformatf("v%0d_bus_req", i), bus_req, vecs[i].e_breq);
            chk($sformatf("v%0d_inst_addr_ok", i), inst_addr_ok, vecs[i].e_iaok);
            chk($sformatf("v%0d_data_addr_ok", i), data_addr_ok, vecs[i].e_daok);
            chk($sformatf("v%0d_inst_data_ok", i), inst_data_ok, vecs[i].e_idok);
            chk($sformatf("v%0d_data_data_ok", i), data_data_ok, vecs[i].e_ddok);
            chk($sformatf("v%0d_err_resp", i), err_resp, vecs[i].e_err);
            if (vecs[i].e_breq) begin
                chk($sformatf("v%0d_bus_addr", i), bus_addr,
                    vecs[i].e_grant ? DADDR : IADDR);
                chk($sformatf("v%0d_bus_wr", i), bus_wr, vecs[i].e_grant);
            end
            if (vecs[i].e_idok)
                chk($sformatf("v%0d_inst_rdata", i), inst_rdata, vecs[i].rdata);
            if (vecs[i].e_ddok)
                chk($sformatf("v%0d_data_rdata", i), data_rdata, vecs[i].rdata);
        end

        // Reset with one request outstanding; its late response must be flagged.
        @(posedge clk); #1;
        drive(1, 0, 1, 0, 32'h0);
        @(negedge clk);
        chk("mid_accept", inst_addr_ok, 1);
        @(posedge clk); #1;
        rst = 1'b1;
        drive(1, 0, 1, 1, 32'h0);
        @(negedge clk);
        chk("mid_rst_bus_req", bus_req, 0);
        chk("mid_rst_inst_addr_ok", inst_addr_ok, 0);
        chk("mid_rst_inst_data_ok", inst_data_ok, 0);
        chk("mid_rst_err_clear", err_resp, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        drive(0, 0, 0, 1, 32'h5555_5555);
        @(negedge clk);
        chk("late_inst_data_ok", inst_data_ok, 0);
        chk("late_data_data_ok", data_data_ok, 0);
        chk("late_err_not_yet", err_resp, 0);
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 32'h0);
        @(negedge clk);
        chk("late_err_set", err_resp, 1);

        // Continuous contention: RR alternates D,I,...; strict keeps data.
        prev_g = OWNER_DATA;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk); #1;
            drive(1, 1, 1, (k > 0), 32'h1000_0000 + 32'(k));
            @(negedge clk);
            g = (RR && k[0]) ? OWNER_INST : OWNER_DATA;
            chk($sformatf("cont%0d_bus_req", k), bus_req, 1);
            chk($sformatf("cont%0d_bus_addr", k), bus_addr, g ? DADDR : IADDR);
            chk($sformatf("cont%0d_data_addr_ok", k), data_addr_ok, g == OWNER_DATA);
            chk($sformatf("cont%0d_inst_addr_ok", k), inst_addr_ok, g == OWNER_INST);
            if (k > 0) begin
                chk($sformatf("cont%0d_data_data_ok", k), data_data_ok, prev_g == OWNER_DATA);
                chk($sformatf("cont%0d_inst_data_ok", k), inst_data_ok, prev_g == OWNER_INST);
            end
            prev_g = g;
        end
        @(posedge clk); #1;
        drive(0, 0, 0, 0, 32'h0);
        @(posedge clk); #1;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
